mnist_train_ctrl: RTL and testbench
===================================

MNIST_TRAIN_CTRL -- requirements
Module: mnist_train_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: width of sample-memory address and sample counters.
REQ-002 Parameter N_EPOCH, default 4: number of training passes over the sample set (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle run request; honoured only in IDLE.
REQ-006 mode  input  1  0 = train, 1 = test; sampled on accepted start.
REQ-007 num_samples  input  ADDR_W  samples per pass; sampled on accepted start.
REQ-008 abort  input  1  terminate current run.
REQ-009 mem_rd  output  1  sample-memory read strobe.
REQ-010 mem_addr  output  ADDR_W  sample-memory address.
REQ-011 mem_data  input  794  sample word, valid the cycle after mem_rd; [793:10] pixels, [9:0] one-hot label.
REQ-012 img  output  794  registered sample broadcast to the ten class learners.
REQ-013 upd_en  output  1  learner parameter-update enable.
REQ-014 cls_result  input  10  per-class learner outputs, combinational from img.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 epoch  output  8  current pass index.
REQ-018 err_cnt  output  ADDR_W  samples where cls_result differed from label, saturating.
REQ-019 skip_cnt  output  ADDR_W  samples with invalid label, saturating.

Function
REQ-020 FSM states SHALL be IDLE, READ, LOAD, APPLY, NEXT, DONE.
REQ-021 IDLE: on start, SHALL latch mode and num_samples, clear mem_addr, epoch, err_cnt and skip_cnt, and go to READ; if num_samples = 0, go to DONE instead.
REQ-022 READ: mem_rd = 1 for exactly one cycle, mem_addr = current sample index; next state LOAD.
REQ-023 LOAD: img SHALL capture mem_data at the end of this cycle; next state APPLY.
REQ-024 APPLY: one cycle; upd_en = 1 only if mode = 0 and popcount(img[9:0]) = 1; next state NEXT.
REQ-025 APPLY: if popcount(img[9:0]) != 1, skip_cnt increments and err_cnt is unchanged; otherwise err_cnt increments when cls_result != img[9:0].
REQ-026 Comparison SHALL use cls_result as seen during APPLY, i.e. before the learner update lands.
REQ-027 NEXT: if mem_addr < num_samples-1, increment mem_addr and go to READ.
REQ-028 NEXT at the last sample: in test mode, or when epoch = N_EPOCH-1, go to DONE; otherwise mem_addr wraps to 0, epoch increments, err_cnt clears, and the next state is READ.
REQ-029 Per-sample latency SHALL be exactly 4 cycles (READ, LOAD, APPLY, NEXT); upd_en is never high outside APPLY.
REQ-030 DONE: done = 1 for one cycle, then IDLE; epoch, err_cnt and skip_cnt hold until the next accepted start.
REQ-031 abort in any non-IDLE state SHALL force IDLE next cycle with upd_en and mem_rd low that cycle, without a done pulse; abort takes priority over all other transitions.
REQ-032 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, no run starts.
REQ-033 img SHALL hold its value outside LOAD.
REQ-034 err_cnt and skip_cnt SHALL saturate at all-ones.

Reset
REQ-035 On rst: state IDLE; img, mem_addr, epoch, err_cnt and skip_cnt = 0; mem_rd, upd_en, busy and done = 0.
REQ-036 rst mid-run SHALL discard the run immediately; no further mem_rd or upd_en until a new start.

Verification
REQ-037 Train, num_samples = 3, N_EPOCH = 2, all labels valid: 6 upd_en pulses spaced 4 cycles apart, mem_addr sequence 0,1,2,0,1,2, done pulses 25 cycles after start, epoch = 1.
REQ-038 Test, num_samples = 4, cls_result wrong on sample 2: upd_en never high, err_cnt = 1, epoch = 0, done after one pass.
REQ-039 Label 10'b0000000011 at sample 1: no upd_en for that sample, skip_cnt = 1, err_cnt unaffected.
REQ-040 num_samples = 0 with start: no mem_rd; done pulses the cycle after the IDLE cycle in which start was accepted.
REQ-041 abort asserted during APPLY of sample 5: upd_en low that cycle, busy low the next cycle, no done; a second start then begins at mem_addr 0.
REQ-042 rst pulsed mid-LOAD, and start pulsed while busy: all outputs return to 0 after rst; the start issued while busy causes no restart and no counter change.

Source files
------------

// File: rtl/mnist_train_ctrl.sv
// mnist_train_ctrl -- sequences training/test passes over a sample memory and
// drives ten per-class learners.
//
// Each sample takes four cycles. READ strobes the memory, LOAD captures the
// returned word into img, APPLY enables the learner update and scores the
// learners, and NEXT advances the sample index or the epoch.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         single-cycle run request, accepted only when idle
//   mode          0 = train, 1 = test (latched on accepted start)
//   num_samples   samples per pass (latched on accepted start)
//   abort         terminate the current run, returning to idle
//   mem_rd        sample-memory read strobe
//   mem_addr      sample-memory address / current sample index
//   mem_data      sample word, valid the cycle after mem_rd:
//                 [793:10] pixels, [9:0] one-hot label
//   img           registered sample broadcast to the class learners
//   upd_en        learner parameter-update enable
//   cls_result    per-class learner outputs (combinational from img)
//   busy          high whenever the controller is not idle
//   done          one-cycle pulse on normal completion
//   epoch         current pass index
//   err_cnt       misclassified samples in the current pass (saturating)
//   skip_cnt      samples with an invalid label over the run (saturating)
module mnist_train_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned N_EPOCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] num_samples,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [793:0]      mem_data,
  output logic [793:0]      img,
  output logic              upd_en,
  input  logic [9:0]        cls_result,
  output logic              busy,
  output logic              done,
  output logic [7:0]        epoch,
  output logic [ADDR_W-1:0] err_cnt,
  output logic [ADDR_W-1:0] skip_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_APPLY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mode_q;
  logic [ADDR_W-1:0] nsamp_q;
  logic              label_ok;
  logic              last_sample;
  logic              last_pass;

  assign label_ok    = ($countones(img[9:0]) == 1);
  assign last_sample = !(mem_addr < (nsamp_q - ADDR_W'(1)));
  assign last_pass   = mode_q || (epoch == 8'(N_EPOCH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Outputs are decoded from state but gated by abort so that an aborted
  // cycle never issues a read, an update or a done pulse.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    upd_en    = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_nxt = (num_samples == '0) ? S_DONE : S_READ;
        end
        S_READ: begin
          mem_rd    = 1'b1;
          state_nxt = S_LOAD;
        end
        S_LOAD: begin
          state_nxt = S_APPLY;
        end
        S_APPLY: begin
          upd_en    = !mode_q && label_ok;
          state_nxt = S_NEXT;
        end
        S_NEXT: begin
          if (last_sample && last_pass) state_nxt = S_DONE;
          else                          state_nxt = S_READ;
        end
        S_DONE: begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 1'b0;
      nsamp_q  <= '0;
      mem_addr <= '0;
      epoch    <= '0;
      err_cnt  <= '0;
      skip_cnt <= '0;
      img      <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            nsamp_q  <= num_samples;
            mem_addr <= '0;
            epoch    <= '0;
            err_cnt  <= '0;
            skip_cnt <= '0;
          end
        end
        S_LOAD: begin
          img <= mem_data;
        end
        S_APPLY: begin
          // cls_result is sampled here, before the learner update lands.
          if (!label_ok) begin
            if (skip_cnt != '1) skip_cnt <= skip_cnt + ADDR_W'(1);
          end else if (cls_result != img[9:0]) begin
            if (err_cnt != '1) err_cnt <= err_cnt + ADDR_W'(1);
          end
        end
        S_NEXT: begin
          if (!last_sample) begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end else if (!last_pass) begin
            mem_addr <= '0;
            epoch    <= epoch + 8'd1;
            err_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_train_ctrl.sv
// Testbench for mnist_train_ctrl: a sample memory and a simple learner model
// surround the controller; each run is predicted from the sample contents.
module tb_mnist_train_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned NE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] num_samples;
  logic          abort;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [793:0]  mem_data;
  logic [793:0]  img;
  logic          upd_en;
  logic [9:0]    cls_result;
  logic          busy;
  logic          done;
  logic [7:0]    epoch;
  logic [AW-1:0] err_cnt;
  logic [AW-1:0] skip_cnt;

  int total = 0;
  int bad   = 0;

  logic [793:0] mem [16];

  mnist_train_ctrl #(.ADDR_W(AW), .N_EPOCH(NE)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .num_samples(num_samples), .abort(abort), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .img(img), .upd_en(upd_en),
    .cls_result(cls_result), .busy(busy), .done(done), .epoch(epoch),
    .err_cnt(err_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  // Sample memory: data valid the cycle after the read strobe, garbage otherwise.
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : ~mem_data;

  // Learner model: answers the label, except pixel bit 10 flips class 0.
  assign cls_result = img[9:0] ^ {9'b0, img[10]};

  task automatic chk(input string tag, input logic [793:0] obs, input logic [793:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ones10(input logic [9:0] v);
    int s = 0;
    for (int k = 0; k < 10; k++) s += int'(v[k]);
    return s;
  endfunction

  // lab_mode: 0 random, 1 all valid/correct, 2 all invalid,
  //           3 sample 1 labelled 2'b11, 4 all valid with sample 2 misclassified
  task automatic do_run(input bit m, input int n, input int lab_mode);
    int exp_rd[$];
    int got_rd[$];
    int exp_up[$];
    int got_up[$];
    int ep, ninv, nwrong, exp_done, done_cyc, exp_skip;
    bit valid [16];
    logic [793:0] w;
    logic [9:0] lab;
    int a, b;
    ninv = 0;
    nwrong = 0;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int j = 0; j < 25; j++) w = {w[761:0], 32'($urandom)};
      a = int'($urandom_range(0, 9));
      b = (a + 1 + int'($urandom_range(0, 8))) % 10;
      lab = 10'(1 << a);
      if (lab_mode == 2 || (lab_mode == 0 && $urandom_range(0, 3) == 0))
        lab = ($urandom_range(0, 3) == 0) ? 10'd0 : (lab | 10'(1 << b));
      if (lab_mode == 3 && i == 1) lab = 10'b0000000011;
      w[9:0] = lab;
      if (lab_mode == 1 || lab_mode == 3) w[10] = 1'b0;
      if (lab_mode == 4) w[10] = (i == 2);
      mem[i] = w;
      valid[i] = (ones10(lab) == 1);
      if (!valid[i]) ninv++;
      else if (w[10]) nwrong++;
    end
    ep = m ? 1 : int'(NE);
    for (int e = 0; e < ep; e++)
      for (int i = 0; i < n; i++) begin
        exp_rd.push_back((1 + 4 * (e * n + i)) * 256 + i);
        if (!m && valid[i]) exp_up.push_back(3 + 4 * (e * n + i));
      end
    exp_done = (n == 0) ? 1 : 1 + 4 * n * ep;
    exp_skip = (ep * ninv > 15) ? 15 : ep * ninv;

    @(negedge clk);
    start = 1'b1; mode = m; num_samples = AW'(n);
    #1;
    chk("idle_busy", busy, 1'b0);
    done_cyc = -1;
    for (int c = 1; c <= exp_done + 8 && done_cyc < 0; c++) begin
      @(negedge clk);
      // A second start while busy, with different settings, must be ignored.
      start = (c == 2); mode = ~m; num_samples = AW'($urandom);
      #1;
      if (mem_rd) got_rd.push_back(c * 256 + int'(mem_addr));
      if (upd_en) got_up.push_back(c);
      if (done) done_cyc = c;
    end
    start = 1'b0;
    chk("rd_count", exp_rd.size(), got_rd.size());
    for (int k = 0; k < exp_rd.size() && k < got_rd.size(); k++)
      chk("rd_cycle_addr", got_rd[k], exp_rd[k]);
    chk("upd_count", got_up.size(), exp_up.size());
    for (int k = 0; k < exp_up.size() && k < got_up.size(); k++)
      chk("upd_cycle", got_up[k], exp_up[k]);
    chk("done_cycle", done_cyc, exp_done);
    chk("epoch", epoch, (n == 0) ? 0 : ep - 1);
    chk("err_cnt", err_cnt, nwrong);
    chk("skip_cnt", skip_cnt, exp_skip);
    if (n > 0) chk("img_last", img, mem[n-1]);
    @(negedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    chk("epoch_hold", epoch, (n == 0) ? 0 : ep - 1);
    chk("skip_hold", skip_cnt, exp_skip);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; num_samples = '0; abort = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_upd_en", upd_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_skip", skip_cnt, 0);
    chk("rst_img", img, 0);
    @(negedge clk);
    rst = 1'b0;

    do_run(1'b0, 3, 1);   // two-epoch train, all valid
    do_run(1'b1, 4, 4);   // test pass, one misclassification
    do_run(1'b0, 4, 3);   // invalid label at sample 1
    do_run(1'b0, 0, 0);   // empty run
    do_run(1'b0, 15, 2);  // skip counter saturation
    for (int r = 0; r < 6; r++)
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(1, 15)), 0);

    // Abort during APPLY of sample 5 (cycle 23 after start).
    mem[5][9:0] = 10'b0000100000;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; num_samples = AW'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_busy_before", busy, 1'b1);
    chk("abort_upd_en", upd_en, 1'b0);
    chk("abort_mem_rd", mem_rd, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_done", done, 1'b0);
    do_run(1'b0, 6, 0);   // restart from address 0 after abort

    // start and abort together in idle: no run.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_idle", busy, 1'b0);
    chk("start_abort_rd", mem_rd, 1'b0);

    // Reset in LOAD of sample 0.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; num_samples = AW'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_epoch", epoch, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_skip", skip_cnt, 0);
    chk("midrst_img", img, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("postrst_quiet", {busy, mem_rd, upd_en, done}, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
